// File: rtl/line_fill_pkg.sv
// Shared types and constants for the instruction-cache line fill engine.
package line_fill_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int LINE_WORDS = 8;
   localparam int WORD_IDX_W = 3;
   localparam int LINE_W     = 256;
   localparam int TAG_W      = 27;

   function automatic logic [31:0] word_addr(input logic [TAG_W-1:0]      tag,
                                             input logic [WORD_IDX_W-1:0] idx);
      return {tag, idx, 2'b00};
   endfunction

endpackage

// File: rtl/fill_watchdog.sv
// Counts consecutive stalled memory cycles; expired flags the cycle that reaches the limit.
module fill_watchdog
   import line_fill_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int              CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

   // count holds the number of earlier stalled cycles, so this is the TIMEOUT_CYCLES-th one
   assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/line_fill_unit.sv
// Critical-word-first line refill engine between the instruction cache and word-wide memory.
module line_fill_unit
   import line_fill_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] START_ADDRESS  = 32'h0040_0000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_i,
   input  logic [31:0]       req_addr_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [LINE_W-1:0] line_o,
   output logic [TAG_W-1:0]  line_tag_o,
   output logic              crit_valid_o,
   output logic [31:0]       crit_word_o,
   output logic              err_o,
   output logic              mem_ce_n_o,
   output logic              mem_oe_n_o,
   output logic              mem_we_n_o,
   output logic [31:0]       mem_addr_o,
   input  logic [31:0]       mem_data_i,
   input  logic              mem_hold_i
);

   localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(LINE_WORDS - 1);

   state_t                state;
   state_t                state_next;
   logic [TAG_W-1:0]      tag;
   logic [WORD_IDX_W-1:0] idx;
   logic [WORD_IDX_W-1:0] cnt;
   logic [LINE_W-1:0]     fill;
   logic [LINE_W-1:0]     fill_merged;
   logic                  legal;
   logic                  accept;
   logic                  illegal;
   logic                  complete;
   logic                  last_word;
   logic                  wd_enable;
   logic                  expired;

   assign legal     = (req_addr_i >= START_ADDRESS);
   assign accept    = (state == IDLE) && req_i && legal;
   assign illegal   = (state == IDLE) && req_i && !legal;
   // abort takes priority, so an aborted cycle never counts as a completion
   assign complete  = (state == READ) && !mem_hold_i && !abort_i;
   assign last_word = (cnt == LAST_WORD);
   assign wd_enable = (state == READ) && mem_hold_i && !abort_i;

   fill_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (!wd_enable),
      .enable  (wd_enable),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = READ;
         READ: begin
            if (abort_i || expired)
               state_next = IDLE;
            else if (!mem_hold_i)
               state_next = last_word ? DONE : GAP;
         end
         GAP:     state_next = abort_i ? IDLE : READ;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_o     = (state != IDLE);
      done_o     = (state == DONE);
      mem_ce_n_o = (state != READ);
      mem_oe_n_o = (state != READ);
      mem_addr_o = (state == READ) ? word_addr(tag, idx) : '0;
   end

   assign mem_we_n_o = 1'b1;

   always_comb begin
      fill_merged = fill;
      fill_merged[{idx, 5'b00000} +: 32] = mem_data_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag          <= '0;
         idx          <= '0;
         cnt          <= '0;
         fill         <= '0;
         line_o       <= '0;
         line_tag_o   <= '0;
         crit_word_o  <= '0;
         crit_valid_o <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         err_o        <= illegal || expired;
         crit_valid_o <= complete && (cnt == '0);
         if (accept) begin
            tag <= req_addr_i[31:5];
            idx <= req_addr_i[4:2];
            cnt <= '0;
         end
         if (complete) begin
            fill <= fill_merged;
            idx  <= idx + 1'b1;
            cnt  <= cnt + 1'b1;
            if (cnt == '0)
               crit_word_o <= mem_data_i;
            // publish the whole line only when the final word lands
            if (last_word) begin
               line_o     <= fill_merged;
               line_tag_o <= tag;
            end
         end
      end
   end

endmodule

// File: doc/line_fill_unit.md
# line_fill_unit

Miss-refill engine between the instruction cache and word-wide main memory. On a cache miss it fetches the 8-word (32-byte) line containing the missed address, critical word first with wrap-around, over the memory's ce_n/oe_n/hold handshake. It forwards the critical word early and hands the assembled 256-bit line to the cache with a one-cycle done pulse. Writes are never issued.

## Interface
- TIMEOUT_CYCLES, 64, maximum consecutive hold-high cycles per word before the fill aborts with error.
- START_ADDRESS, 32'h00400000, lowest legal fetch address; lower requests raise err_o immediately.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_i  in  1  fill request, sampled in IDLE only.
- req_addr_i  in  32  missed byte address; bits [1:0] ignored.
- abort_i  in  1  cancel the fill in progress.
- busy_o  out  1  fill in progress (READ/GAP/DONE).
- done_o  out  1  one-cycle pulse: line_o valid.
- line_o  out  256  assembled line; word i at [32i+:32], where i = address bits [4:2].
- line_tag_o  out  27  req_addr_i[31:5] of the completed line.
- crit_valid_o  out  1  one-cycle pulse: crit_word_o valid.
- crit_word_o  out  32  requested word.
- err_o  out  1  one-cycle pulse on timeout or illegal address.
- mem_ce_n_o  out  1  memory chip enable, active-low.
- mem_oe_n_o  out  1  memory output enable, active-low.
- mem_we_n_o  out  1  constant 1.
- mem_addr_o  out  32  word address presented to memory.
- mem_data_i  in  32  memory read data.
- mem_hold_i  in  1  memory busy; data is valid in a READ cycle where it is 0.

## Operation
- States: IDLE, READ, GAP, DONE.
- IDLE: req_i=1 with req_addr_i >= START_ADDRESS latches base={addr[31:5],5'b0}, idx=addr[4:2], cnt=0, then goes to READ.
- IDLE: req_i=1 with req_addr_i < START_ADDRESS pulses err_o next cycle and stays in IDLE.
- READ: ce_n=0, oe_n=0, mem_addr_o=base+{idx,2'b00}.
  - Cycle with mem_hold_i=0 is a completion: line word idx <= mem_data_i, idx <= idx+1 mod 8, cnt++.
  - Go to GAP, or to DONE if cnt was 7.
- GAP: one cycle with ce_n=1, oe_n=1, then READ. Each word is a separate memory access.
- DONE: done_o=1 for exactly one cycle, then IDLE.
  - line_o and line_tag_o are updated at DONE entry and stay stable until the next DONE.
- Critical word: first completion (cnt=0) registers crit_word_o and pulses crit_valid_o the following cycle.
- Watchdog counts consecutive READ cycles with hold=1. At TIMEOUT_CYCLES: err_o pulse, go to IDLE, no done_o, line_o unchanged.
- abort_i in READ/GAP: IDLE next cycle with ce_n=1, no done_o.
  - abort_i wins over a simultaneous final completion.
  - abort_i in IDLE/DONE is ignored.
- req_i outside IDLE is ignored; the requester must hold it until busy_o rises.
- Outputs outside READ: ce_n=1, oe_n=1, mem_addr_o=0.

## Timing
- Reset values: busy_o=0, done_o=0, crit_valid_o=0, err_o=0, line_o=0, line_tag_o=0, crit_word_o=0, mem_ce_n_o=1, mem_oe_n_o=1, mem_we_n_o=1, mem_addr_o=0, state=IDLE, watchdog=0.
- Reset mid-fill returns to IDLE immediately; partial line is discarded.
- With H wait cycles per word (req accepted in cycle 0):
  - word k READ starts at 1+k(H+2) and completes at 1+k(H+2)+H;
  - crit_valid_o at 2+H; done_o at 16+8H.
- busy_o is high from cycle 1 through the DONE cycle. The next request is accepted at the earliest in the cycle after DONE.
- Address wrap: idx 7 -> 0 within the line; base is never incremented.

## Structure
- Package line_fill_pkg: state enum (IDLE, READ, GAP, DONE), LINE_WORDS=8, WORD_IDX_W=3, LINE_W=256, TAG_W=27.
- Sub-module fill_watchdog: counter with clear/enable inputs and an expired output at TIMEOUT_CYCLES. Everything else lives in line_fill_unit.

## Test plan
- H=0, req 0x00400024 -> mem_addr_o sequence 0x..24,28,2C,30,34,38,3C,20; crit_valid_o at cycle 2 with mem[0x00400024]; done_o at cycle 16; line_o word i = mem[0x00400020+4i]; line_tag_o=0x0400024>>5 equivalent (addr[31:5]).
- H=15, req 0x00400000 -> crit_valid_o at cycle 17; done_o at cycle 136; ce_n high for exactly one cycle between words.
- abort_i in cycle 20 of an H=15 fill -> IDLE in cycle 21, no done_o, line_o keeps the previous line; abort coincident with 8th completion -> no done_o.
- mem_hold_i stuck at 1 -> err_o pulse after 64 hold cycles, IDLE, ce_n=1; req 0x003FFFFC -> err_o, no memory access.
- reset_n low mid-READ -> all outputs at reset values immediately; new req afterwards completes normally.
- req_i held through DONE and the back-to-back second request -> second fill starts the cycle after DONE; req pulses while busy are ignored.
